// File: rtl/ldr_bridge_if.sv
// Host-download / core-loader signal bundle for ldr_bridge.
// ldr_sum is present only when LDR_CHECKSUM_EN is defined.
interface ldr_bridge_if;
  // Host side: a byte moves on every cycle with ioctl_wr=1; ioctl_wait=1 asks the host
  // to stop strobing, one strobe in the same cycle is still absorbed. Core side: ldr_wr
  // plus addr/data stay stable until ldr_ack rises; the next request waits for ldr_ack=0.
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [19:0] ldr_addr;
  logic [7:0]  ldr_wdat;
  logic        ldr_aen;
  logic        ldr_wr;
  logic        ldr_ack;
  logic        ldr_done;
  logic        ldr_ovf;
`ifdef LDR_CHECKSUM_EN
  logic [15:0] ldr_sum;
`endif

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
`ifdef LDR_CHECKSUM_EN
    output ldr_sum,
`endif
    output ioctl_wait, ldr_addr, ldr_wdat, ldr_aen, ldr_wr, ldr_done, ldr_ovf
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
`ifdef LDR_CHECKSUM_EN
    input  ldr_sum,
`endif
    input  ioctl_wait, ldr_addr, ldr_wdat, ldr_aen, ldr_wr, ldr_done, ldr_ovf
  );
endinterface

// File: rtl/ldr_bridge.sv
// Buffers host download bytes in a small FIFO and drains them to the core loader
// over a level ack handshake. Optional running checksum under LDR_CHECKSUM_EN.
module ldr_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  ldr_bridge_if.slave                   bus,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C  = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [27:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           ack_q, dl_q, fell_seen;
  logic           done_q, ovf_q, wait_q;
  logic [19:0]    addr_q;
  logic [7:0]     wdat_q;
  logic           push_req, push, pop, load, empty, full, ack_rise;
  logic           wr_o, aen_o;
  logic [27:0]    head;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^bus.ioctl_addr[24:20];

  always_comb begin
    empty    = (count == '0);
    full     = (count == DEPTH_C);
    push_req = bus.ioctl_wr & bus.ioctl_download & ~done_q;
    push     = push_req & ~full;
    ack_rise = bus.ldr_ack & ~ack_q;
    head     = mem[rd_ptr];
  end

  // Drain FSM: state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM: next state; never start a request while the core still holds ack
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!empty && !bus.ldr_ack) state_nxt = S_REQ;
      S_REQ:     if (ack_rise)               state_nxt = S_RELEASE;
      S_RELEASE: if (!bus.ldr_ack)           state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // Drain FSM: outputs and datapath strobes
  always_comb begin
    load  = (state == S_IDLE) && (state_nxt == S_REQ);
    pop   = (state == S_REQ) && ack_rise;
    wr_o  = (state == S_REQ);
    aen_o = ~reset & ~done_q & (bus.ioctl_download | ~empty | (state != S_IDLE));
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset && push) mem[wr_ptr] <= {bus.ioctl_addr[19:0], bus.ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      dl_q      <= 1'b0;
      fell_seen <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      // Registered from the next count so it already reflects this cycle's push/pop
      wait_q    <= (count_nxt >= WAIT_C);
      ovf_q     <= ovf_q | (push_req & full);
      ack_q     <= bus.ldr_ack;
      dl_q      <= bus.ioctl_download;
      fell_seen <= fell_seen | (dl_q & ~bus.ioctl_download);
      done_q    <= done_q | (fell_seen & empty & (state == S_IDLE));
      if (load) begin
        addr_q <= head[27:8];
        wdat_q <= head[7:0];
      end
    end
  end

`ifdef LDR_CHECKSUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk_sys) begin
    if (reset)              sum_q <= '0;
    else if (pop && !done_q) sum_q <= sum_q + {8'h00, wdat_q};
  end
  assign bus.ldr_sum = sum_q;
`endif

  assign bus.ioctl_wait = wait_q;
  assign bus.ldr_addr   = addr_q;
  assign bus.ldr_wdat   = wdat_q;
  assign bus.ldr_wr     = wr_o;
  assign bus.ldr_aen    = aen_o;
  assign bus.ldr_done   = done_q;
  assign bus.ldr_ovf    = ovf_q;
  assign dbg_state      = state;
  assign dbg_count      = count;
endmodule

// File: tb/tb_ldr_bridge.sv
// Directed plus randomized bench for ldr_bridge with a queue-based reference of
// accepted bytes and a randomly delayed core responder.
module tb_ldr_bridge;
  localparam int DEPTH = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;
  logic       ack_model, ack_man;

  int          total = 0;
  int          bad = 0;
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];
  bit          resp_en = 1'b0;
  logic [15:0] sum_model;

  always #5 clk_sys = ~clk_sys;

  ldr_bridge_if bus ();
  assign bus.ldr_ack = ack_model | ack_man;

  ldr_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core loader model: acks each request after a random delay, logging what it saw
  initial begin : core_model
    int d, h;
    ack_model = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (resp_en && bus.ldr_wr === 1'b1 && !ack_model) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk_sys);
        if (bus.ldr_wr === 1'b1) begin
          got_q.push_back({bus.ldr_addr, bus.ldr_wdat});
          ack_model = 1'b1;
          h = $urandom_range(1, 3);
          repeat (h) @(negedge clk_sys);
          ack_model = 1'b0;
        end
      end
    end
  end

  // Host byte write; when honour is set the host waits for ioctl_wait=0 first
  task automatic host_write(input logic [24:0] a, input logic [7:0] d, input bit honour);
    int guard = 0;
    while (honour && bus.ioctl_wait === 1'b1 && guard < 500) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 500) check("wait_timeout", 32'd1, 32'd0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  // Reference: every accepted byte appears at the core in order, address mod 2^20
  task automatic model_push(input logic [24:0] a, input logic [7:0] d);
    logic [31:0] wrapped;
    wrapped = {7'd0, a} % 32'h0010_0000;
    exp_q.push_back({wrapped[19:0], d});
    sum_model = sum_model + 16'(d);
  endtask

  task automatic do_reset();
    resp_en = 1'b0;
    ack_man = 1'b0;
    bus.ioctl_wr = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    sum_model = '0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (!(dbg_count == 0 && bus.ldr_wr === 1'b0 && bus.ldr_ack === 1'b0) && guard < 3000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_entry"}, {4'd0, got_q[i]}, {4'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic manual_ack();
    int guard = 0;
    while (bus.ldr_wr !== 1'b1 && guard < 50) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 50) check("req_timeout", 32'd1, 32'd0);
    ack_man = 1'b1;
    @(negedge clk_sys);
    ack_man = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},    bus.ldr_wr,     32'd0);
    check({tag, "_aen"},   bus.ldr_aen,    32'd0);
    check({tag, "_done"},  bus.ldr_done,   32'd0);
    check({tag, "_ovf"},   bus.ldr_ovf,    32'd0);
    check({tag, "_wait"},  bus.ioctl_wait, 32'd0);
    check({tag, "_addr"},  bus.ldr_addr,   32'd0);
    check({tag, "_wdat"},  bus.ldr_wdat,   32'd0);
    check({tag, "_count"}, dbg_count,      32'd0);
`ifdef LDR_CHECKSUM_EN
    check({tag, "_sum"},   bus.ldr_sum,    32'd0);
`endif
  endtask

  initial begin : main
    int guard;
    logic [24:0] a;
    logic [7:0]  d;
    reset = 1'b1;
    ack_man = 1'b0;
    sum_model = '0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("aen_download", bus.ldr_aen, 32'd1);

    // Single byte, ack rises on the third cycle of ldr_wr
    host_write(25'h00010, 8'hA5, 1'b0);
    model_push(25'h00010, 8'hA5);
    check("lat_wr_low", bus.ldr_wr, 32'd0);
    check("lat_count", dbg_count, 32'd1);
    @(negedge clk_sys);
    check("single_wr", bus.ldr_wr, 32'd1);
    check("single_addr", bus.ldr_addr, 32'h00010);
    check("single_wdat", bus.ldr_wdat, 32'hA5);
    repeat (2) begin
      @(negedge clk_sys);
      check("single_hold_wr", bus.ldr_wr, 32'd1);
      check("single_hold_addr", bus.ldr_addr, 32'h00010);
    end
    ack_man = 1'b1;
    @(negedge clk_sys);
    check("single_wr_clear", bus.ldr_wr, 32'd0);
    check("single_pop", dbg_count, 32'd0);
    ack_man = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("single_no_reissue", bus.ldr_wr, 32'd0);
`ifdef LDR_CHECKSUM_EN
    check("single_sum", bus.ldr_sum, {16'd0, sum_model});
`endif

    // Backpressure and overflow with the core stalled
    do_reset();
    bus.ioctl_download = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      d = 8'(8'h30 + n);
      host_write(25'(32'h100 + n), d, 1'b0);
      if (n <= DEPTH) model_push(25'(32'h100 + n), d);
      check("bp_count", dbg_count, (n < DEPTH) ? n : DEPTH);
      check("bp_wait", bus.ioctl_wait, (n >= DEPTH - 1) ? 32'd1 : 32'd0);
      check("bp_ovf", bus.ldr_ovf, (n > DEPTH) ? 32'd1 : 32'd0);
    end
    resp_en = 1'b1;
    wait_drain();
    compare_queues("bp_order");
    check("bp_ovf_sticky", bus.ldr_ovf, 32'd1);

    // Ordering with address wrap at 20 bits
    do_reset();
    bus.ioctl_download = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 25'(32'h1FFFF0 + i);
      d = 8'(i + 1);
      host_write(a, d, 1'b1);
      model_push(a, d);
    end
    wait_drain();
    compare_queues("wrap_order");
`ifdef LDR_CHECKSUM_EN
    check("wrap_sum", bus.ldr_sum, {16'd0, sum_model});
`endif

    // Randomized traffic with random gaps and responder delays
    for (int i = 0; i < 40; i++) begin
      a = 25'($urandom);
      d = 8'($urandom);
      host_write(a, d, 1'b1);
      model_push(a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end
    wait_drain();
    compare_queues("rand_order");
    check("rand_no_ovf", bus.ldr_ovf, 32'd0);
`ifdef LDR_CHECKSUM_EN
    check("rand_sum", bus.ldr_sum, {16'd0, sum_model});
`endif

    // Done deferred until the queue drains, then later downloads ignored
    do_reset();
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_write(25'(32'h200 + i), 8'(8'hC0 + i), 1'b0);
      model_push(25'(32'h200 + i), 8'(8'hC0 + i));
    end
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("done_pending0", bus.ldr_done, 32'd0);
    check("done_aen_busy", bus.ldr_aen, 32'd1);
    manual_ack();
    manual_ack();
    check("done_pending2", bus.ldr_done, 32'd0);
    manual_ack();
    guard = 0;
    while (bus.ldr_done !== 1'b1 && guard < 6) begin
      @(negedge clk_sys);
      guard++;
    end
    check("done_set", bus.ldr_done, 32'd1);
    check("done_empty", dbg_count, 32'd0);
`ifdef LDR_CHECKSUM_EN
    check("done_sum", bus.ldr_sum, {16'd0, sum_model});
`endif
    bus.ioctl_download = 1'b1;
    host_write(25'h300, 8'h77, 1'b0);
    @(negedge clk_sys);
    check("done_ignore_count", dbg_count, 32'd0);
    check("done_ignore_wr", bus.ldr_wr, 32'd0);
    check("done_aen_off", bus.ldr_aen, 32'd0);
    check("done_sticky", bus.ldr_done, 32'd1);

    // Reset in the middle of a request, download still active
    do_reset();
    bus.ioctl_download = 1'b1;
    host_write(25'h0ABCD, 8'h5A, 1'b0);
    guard = 0;
    while (bus.ldr_wr !== 1'b1 && guard < 10) begin
      @(negedge clk_sys);
      guard++;
    end
    check("midreq_wr_up", bus.ldr_wr, 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    check_all_zero("midreq");
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("midreq_no_reissue", bus.ldr_wr, 32'd0);
    check("midreq_count", dbg_count, 32'd0);

`ifdef LDR_CHECKSUM_EN
    // Checksum wraps modulo 2^16
    do_reset();
    bus.ioctl_download = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 300; i++) host_write(25'(i), 8'hFF, 1'b1);
    wait_drain();
    check("sum_300xff", bus.ldr_sum, 32'h2AD4);
    check("sum_300_pops", got_q.size(), 32'd300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
